// File: rtl/vga_pkg.sv
// Shared VGA timing constants for the 640x480@60 Hz raster and its helpers.
package vga_pkg;

    // Counter width; both totals must fit in it.
    localparam int unsigned CNT_W = 10;

    // Default horizontal timing, in pixels.
    localparam int unsigned DEFAULT_H_VISIBLE = 640;
    localparam int unsigned DEFAULT_H_FP      = 16;
    localparam int unsigned DEFAULT_H_SYNC    = 96;
    localparam int unsigned DEFAULT_H_BP      = 48;

    // Default vertical timing, in lines.
    localparam int unsigned DEFAULT_V_VISIBLE = 480;
    localparam int unsigned DEFAULT_V_FP      = 10;
    localparam int unsigned DEFAULT_V_SYNC    = 2;
    localparam int unsigned DEFAULT_V_BP      = 33;

    localparam int unsigned DEFAULT_H_TOTAL =
        DEFAULT_H_VISIBLE + DEFAULT_H_FP + DEFAULT_H_SYNC + DEFAULT_H_BP;
    localparam int unsigned DEFAULT_V_TOTAL =
        DEFAULT_V_VISIBLE + DEFAULT_V_FP + DEFAULT_V_SYNC + DEFAULT_V_BP;

    // Registered per-pixel flags, all decoded from the next counter values.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic video_on;
        logic frame_start;
    } sync_flags_t;

    // Flag values held while in reset: syncs idle high, nothing else asserted.
    localparam sync_flags_t FLAGS_RESET = '{hsync: 1'b1, vsync: 1'b1,
                                           video_on: 1'b0, frame_start: 1'b0};

    // True when lo <= val <= hi (inclusive window decode).
    function automatic logic in_range(input logic [CNT_W-1:0] val,
                                      input logic [CNT_W-1:0] lo,
                                      input logic [CNT_W-1:0] hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/toggle_sync.sv
// Two-flop synchronizer plus edge detector for a slow toggle from another clock domain.
// Every level change of async_in (rising or falling) produces a one-cycle evt pulse.
module toggle_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic evt
);

    logic [1:0] sync_q;
    logic       prev_q;

    // Synchronize the input, then keep the previous synchronized value for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], async_in};
            prev_q <= sync_q[1];
        end
    end

    // Any difference between synchronized and previous value is one event.
    assign evt = sync_q[1] ^ prev_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: h/v counters, active-low syncs, video enable, frame start,
// and a game tick that moves slow update events into the start of vertical blanking.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE = DEFAULT_H_VISIBLE,
    parameter int unsigned H_FP      = DEFAULT_H_FP,
    parameter int unsigned H_SYNC    = DEFAULT_H_SYNC,
    parameter int unsigned H_BP      = DEFAULT_H_BP,
    parameter int unsigned V_VISIBLE = DEFAULT_V_VISIBLE,
    parameter int unsigned V_FP      = DEFAULT_V_FP,
    parameter int unsigned V_SYNC    = DEFAULT_V_SYNC,
    parameter int unsigned V_BP      = DEFAULT_V_BP
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             update,
    output logic [CNT_W-1:0] h_count,
    output logic [CNT_W-1:0] v_count,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             frame_start,
    output logic             game_tick
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FP + V_SYNC - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    sync_flags_t      flags_q, flags_d;
    logic             tick_q, tick_d;
    logic             pending_q, pending_d;
    logic             h_wrap;
    logic             tick_slot;
    logic             update_evt;

    toggle_sync u_update_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (update),
        .evt      (update_evt)
    );

    // Next raster position: h wraps at end of line, v advances only on that wrap.
    always_comb begin
        h_wrap = (h_q == H_LAST);
        h_d    = h_wrap ? '0 : h_q + ONE;
        v_d    = v_q;
        if (h_wrap) begin
            v_d = (v_q == V_LAST) ? '0 : v_q + ONE;
        end
    end

    // Decode flags from the next position so they line up with the counters they accompany.
    always_comb begin
        flags_d             = FLAGS_RESET;
        flags_d.hsync       = !in_range(h_d, HS_START, HS_END);
        flags_d.vsync       = !in_range(v_d, VS_START, VS_END);
        flags_d.video_on    = (h_d < H_VIS) && (v_d < V_VIS);
        flags_d.frame_start = (h_d == '0) && (v_d == '0);
    end

    // Tick only if an event was already pending; an event in the tick cycle itself wins
    // over the clear so it is carried to the next frame.
    always_comb begin
        tick_slot = (h_d == '0) && (v_d == V_VIS);
        tick_d    = tick_slot && pending_q;
        pending_d = pending_q;
        if (tick_slot) begin
            pending_d = 1'b0;
        end
        if (update_evt) begin
            pending_d = 1'b1;
        end
    end

    // Raster counters; reset parks them on the last pixel so the first edge starts a frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_q <= H_LAST;
            v_q <= V_LAST;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    // Registered sync flags, game tick and pending event flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q   <= FLAGS_RESET;
            tick_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            flags_q   <= flags_d;
            tick_q    <= tick_d;
            pending_q <= pending_d;
        end
    end

    assign h_count     = h_q;
    assign v_count     = v_q;
    assign hsync       = flags_q.hsync;
    assign vsync       = flags_q.vsync;
    assign video_on    = flags_q.video_on;
    assign frame_start = flags_q.frame_start;
    assign game_tick   = tick_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen. A reduced-timing instance (32x20 raster, 640-cycle frame) exercises
// the full frame, sync windows and game tick behaviour; a default-timing instance is checked
// over its reset state and first 640x480 line.
module tb_vga_sync_gen;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       update = 1'b0;

    logic [9:0] s_h, s_v;
    logic       s_hs, s_vs, s_von, s_fs, s_tick;
    logic [9:0] d_h, d_v;
    logic       d_hs, d_vs, d_von, d_fs, d_tick;

    int total = 0;
    int bad = 0;

    // Reduced raster: hsync low h in [20,25], vsync low v in [14,15], tick at (0,12).
    vga_sync_gen #(
        .H_VISIBLE (16), .H_FP (4), .H_SYNC (6), .H_BP (6),
        .V_VISIBLE (12), .V_FP (2), .V_SYNC (2), .V_BP (4)
    ) u_small (
        .clk         (clk),
        .reset_n     (reset_n),
        .update      (update),
        .h_count     (s_h),
        .v_count     (s_v),
        .hsync       (s_hs),
        .vsync       (s_vs),
        .video_on    (s_von),
        .frame_start (s_fs),
        .game_tick   (s_tick)
    );

    vga_sync_gen u_full (
        .clk         (clk),
        .reset_n     (reset_n),
        .update      (update),
        .h_count     (d_h),
        .v_count     (d_v),
        .hsync       (d_hs),
        .vsync       (d_vs),
        .video_on    (d_von),
        .frame_start (d_fs),
        .game_tick   (d_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;      // posedges since reset release
        int h;
        int v;
        bit hs;
        bit vs;
        bit von;
        bit fs;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pos(input int h, input int v, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (s_h == 10'(h) && s_v == 10'(v)) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL %s: position (%0d,%0d) not reached, at (%0d,%0d)", name, h, v, s_h, s_v);
        end
    endtask

    task automatic run_count(input int n, output int ticks);
        ticks = 0;
        repeat (n) begin
            @(negedge clk);
            if (s_tick) ticks++;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " small h"}, 32'(s_h), 31);
        check({tag, " small v"}, 32'(s_v), 19);
        check({tag, " small hsync"}, 32'(s_hs), 1);
        check({tag, " small vsync"}, 32'(s_vs), 1);
        check({tag, " small video_on"}, 32'(s_von), 0);
        check({tag, " small frame_start"}, 32'(s_fs), 0);
        check({tag, " small game_tick"}, 32'(s_tick), 0);
        check({tag, " full h"}, 32'(d_h), 799);
        check({tag, " full v"}, 32'(d_v), 524);
        check({tag, " full hsync"}, 32'(d_hs), 1);
        check({tag, " full vsync"}, 32'(d_vs), 1);
        check({tag, " full video_on"}, 32'(d_von), 0);
        check({tag, " full frame_start"}, 32'(d_fs), 0);
        check({tag, " full game_tick"}, 32'(d_tick), 0);
    endtask

    initial begin
        int cur;
        int ticks;
        int hs_low;
        int hs_first;
        int von_cnt;

        //         n    h   v  hs vs von fs
        vecs[0]  = '{1,   0,  0, 1, 1, 1, 1};
        vecs[1]  = '{16,  15, 0, 1, 1, 1, 0};
        vecs[2]  = '{17,  16, 0, 1, 1, 0, 0};
        vecs[3]  = '{21,  20, 0, 0, 1, 0, 0};
        vecs[4]  = '{26,  25, 0, 0, 1, 0, 0};
        vecs[5]  = '{27,  26, 0, 1, 1, 0, 0};
        vecs[6]  = '{32,  31, 0, 1, 1, 0, 0};
        vecs[7]  = '{33,  0,  1, 1, 1, 1, 0};
        vecs[8]  = '{384, 31, 11, 1, 1, 0, 0};
        vecs[9]  = '{385, 0,  12, 1, 1, 0, 0};
        vecs[10] = '{449, 0,  14, 1, 0, 0, 0};
        vecs[11] = '{512, 31, 15, 1, 0, 0, 0};
        vecs[12] = '{513, 0,  16, 1, 1, 0, 0};
        vecs[13] = '{640, 31, 19, 1, 1, 0, 0};
        vecs[14] = '{641, 0,  0, 1, 1, 1, 1};

        // Reset state while reset_n is held low.
        step(2);
        check_reset_vals("reset");

        // Full reduced frame plus first pixel of the next one.
        reset_n = 1'b1;
        cur = 0;
        foreach (vecs[i]) begin
            step(vecs[i].n - cur);
            cur = vecs[i].n;
            check($sformatf("vec%0d h", i), 32'(s_h), 32'(vecs[i].h));
            check($sformatf("vec%0d v", i), 32'(s_v), 32'(vecs[i].v));
            check($sformatf("vec%0d hsync", i), 32'(s_hs), 32'(vecs[i].hs));
            check($sformatf("vec%0d vsync", i), 32'(s_vs), 32'(vecs[i].vs));
            check($sformatf("vec%0d video_on", i), 32'(s_von), 32'(vecs[i].von));
            check($sformatf("vec%0d frame_start", i), 32'(s_fs), 32'(vecs[i].fs));
            check($sformatf("vec%0d game_tick", i), 32'(s_tick), 0);
        end

        // Default timing: first line after a fresh reset.
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(1);
        check("full first h", 32'(d_h), 0);
        check("full first v", 32'(d_v), 0);
        check("full first frame_start", 32'(d_fs), 1);
        hs_low = 0;
        hs_first = -1;
        von_cnt = 0;
        for (int i = 0; i < 800; i++) begin
            if (i > 0) step(1);
            if (!d_hs) begin
                if (hs_first < 0) hs_first = int'(d_h);
                hs_low++;
            end
            if (d_von) von_cnt++;
        end
        check("full hsync low cycles", 32'(hs_low), 96);
        check("full hsync start h", 32'(hs_first), 656);
        check("full video_on cycles", 32'(von_cnt), 640);
        step(1);
        check("full wrap h", 32'(d_h), 0);
        check("full wrap v", 32'(d_v), 1);

        // Single mid-frame update: one tick at (0,12), none the following frame.
        wait_pos(5, 3, "A start");
        update = ~update;
        wait_pos(0, 12, "A tick slot");
        check("A tick at (0,12)", 32'(s_tick), 1);
        step(1);
        check("A tick one cycle", 32'(s_tick), 0);
        run_count(639, ticks);
        check("A no tick next frame", 32'(ticks), 0);

        // Five updates in one frame collapse to one tick.
        wait_pos(0, 1, "B start");
        repeat (5) begin
            update = ~update;
            step(8);
        end
        run_count(1280, ticks);
        check("B ticks over two frames", 32'(ticks), 1);

        // Event lands in the tick cycle itself: no tick now, tick next frame.
        wait_pos(29, 11, "C start");
        update = ~update;
        step(3);
        check("C at h", 32'(s_h), 0);
        check("C at v", 32'(s_v), 12);
        check("C no tick this frame", 32'(s_tick), 0);
        run_count(640, ticks);
        check("C ticks next frame", 32'(ticks), 1);
        check("C tick at (0,12)", 32'(s_tick), 1);
        run_count(640, ticks);
        check("C no tick after", 32'(ticks), 0);

        // Mid-frame reset with an event pending.
        wait_pos(10, 6, "D start");
        update = ~update;
        step(5);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_vals("async");
        update = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(1);
        check("D first h", 32'(s_h), 0);
        check("D first v", 32'(s_v), 0);
        check("D frame_start", 32'(s_fs), 1);
        run_count(1280, ticks);
        check("D no tick after reset", 32'(ticks), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
